// File: rtl/modexp_arbiter.sv
// Round-robin front end that shares one modular-exponentiation engine between two requesters.
// It grants a job, starts the engine, waits with a timeout, then holds the result for the winner.
module modexp_arbiter #(
  parameter int WORDSIZE = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [4*WORDSIZE-1:0] req_base,
  input  logic [4*WORDSIZE-1:0] req_modulo,
  input  logic [4*WORDSIZE-1:0] req_exponent,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [2*WORDSIZE-1:0] rsp_result,
  output logic                  rsp_error,
  output logic [2*WORDSIZE-1:0] eng_base,
  output logic [2*WORDSIZE-1:0] eng_modulo,
  output logic [2*WORDSIZE-1:0] eng_exponent,
  output logic                  eng_load,
  input  logic                  eng_done,
  input  logic [2*WORDSIZE-1:0] eng_result,
  output logic                  busy
);

  localparam int W2 = 2 * WORDSIZE;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t         state_reg, state_next;
  logic           ptr_reg, ptr_next;
  logic           winner_reg, winner_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [W2-1:0]  eng_base_reg, eng_base_next;
  logic [W2-1:0]  eng_modulo_reg, eng_modulo_next;
  logic [W2-1:0]  eng_exponent_reg, eng_exponent_next;
  logic [W2-1:0]  rsp_result_reg, rsp_result_next;
  logic           rsp_error_reg, rsp_error_next;

  logic [W2-1:0]  base_slice [2];
  logic [W2-1:0]  modulo_slice [2];
  logic [W2-1:0]  exponent_slice [2];

  logic           grant_any;
  logic           grant_idx;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slice
    assign base_slice[gi]     = req_base[gi*W2 +: W2];
    assign modulo_slice[gi]   = req_modulo[gi*W2 +: W2];
    assign exponent_slice[gi] = req_exponent[gi*W2 +: W2];
  end

  // The preferred requester wins a tie; a lone requester wins regardless of the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = ptr_reg;
    if (req_valid[ptr_reg]) begin
      grant_any = 1'b1;
      grant_idx = ptr_reg;
    end else if (req_valid[~ptr_reg]) begin
      grant_any = 1'b1;
      grant_idx = ~ptr_reg;
    end
  end

  always_comb begin
    state_next        = state_reg;
    ptr_next          = ptr_reg;
    winner_next       = winner_reg;
    cnt_next          = cnt_reg;
    eng_base_next     = eng_base_reg;
    eng_modulo_next   = eng_modulo_reg;
    eng_exponent_next = eng_exponent_reg;
    rsp_result_next   = rsp_result_reg;
    rsp_error_next    = rsp_error_reg;
    req_ready         = 2'b00;
    rsp_valid         = 2'b00;
    eng_load          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_any && !reset) begin
          req_ready[grant_idx] = 1'b1;
          winner_next          = grant_idx;
          ptr_next             = ~grant_idx;
          eng_base_next        = base_slice[grant_idx];
          eng_modulo_next      = modulo_slice[grant_idx];
          eng_exponent_next    = exponent_slice[grant_idx];
          state_next           = LOAD;
        end
      end

      LOAD: begin
        // A zero modulus is rejected here, before the engine is ever started.
        if (eng_modulo_reg == '0) begin
          rsp_result_next = '0;
          rsp_error_next  = 1'b1;
          state_next      = RESP;
        end else begin
          eng_load   = 1'b1;
          cnt_next   = '0;
          state_next = WAIT;
        end
      end

      WAIT: begin
        cnt_next = cnt_reg + CW'(1);
        // The engine's done flag may still be stale from the previous job in the first cycle.
        if (eng_done && (cnt_reg != '0)) begin
          rsp_result_next = eng_result;
          rsp_error_next  = 1'b0;
          state_next      = RESP;
        end else if ((cnt_reg + CW'(1)) == CNT_LAST) begin
          rsp_result_next = '0;
          rsp_error_next  = 1'b1;
          state_next      = RESP;
        end
      end

      RESP: begin
        rsp_valid[winner_reg] = 1'b1;
        if (rsp_ready[winner_reg]) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      ptr_reg          <= 1'b0;
      winner_reg       <= 1'b0;
      cnt_reg          <= '0;
      eng_base_reg     <= '0;
      eng_modulo_reg   <= '0;
      eng_exponent_reg <= '0;
      rsp_result_reg   <= '0;
      rsp_error_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      ptr_reg          <= ptr_next;
      winner_reg       <= winner_next;
      cnt_reg          <= cnt_next;
      eng_base_reg     <= eng_base_next;
      eng_modulo_reg   <= eng_modulo_next;
      eng_exponent_reg <= eng_exponent_next;
      rsp_result_reg   <= rsp_result_next;
      rsp_error_reg    <= rsp_error_next;
    end
  end

  assign eng_base     = eng_base_reg;
  assign eng_modulo   = eng_modulo_reg;
  assign eng_exponent = eng_exponent_reg;
  assign rsp_result   = rsp_result_reg;
  assign rsp_error    = rsp_error_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_modexp_arbiter.sv
// Bench for modexp_arbiter: behavioural engine with stub modes, queue scoreboard,
// a vector table and hand sequences for arbitration, timeout, hold and reset cases.
module tb_modexp_arbiter;

  localparam int WORDSIZE = 8;
  localparam int W2       = 2 * WORDSIZE;
  localparam int TIMEOUT  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*W2-1:0] req_base, req_modulo, req_exponent;
  logic [W2-1:0]   rsp_result, eng_base, eng_modulo, eng_exponent, eng_result;
  logic            rsp_error, eng_load, eng_done, busy;

  always #5 clk = ~clk;

  modexp_arbiter #(.WORDSIZE(WORDSIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base(req_base), .req_modulo(req_modulo), .req_exponent(req_exponent),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_error(rsp_error),
    .eng_base(eng_base), .eng_modulo(eng_modulo), .eng_exponent(eng_exponent),
    .eng_load(eng_load), .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy)
  );

  // Engine: mode 0 = square-and-multiply model, 1 = done stuck low, 2 = done stuck high.
  int            eng_mode = 0;
  logic          real_done = 1'b1;
  logic [W2-1:0] real_result = '0;
  logic [63:0]   acc_m = 64'd0, b_m = 64'd0, mod_m = 64'd1;
  logic [W2-1:0] e_m = '0;

  always @(posedge clk) begin
    if (eng_load) begin
      mod_m     <= 64'(eng_modulo);
      acc_m     <= 64'd1 % 64'(eng_modulo);
      b_m       <= 64'(eng_base) % 64'(eng_modulo);
      e_m       <= eng_exponent;
      real_done <= 1'b0;
    end else if (!real_done) begin
      if (e_m == '0) begin
        real_done   <= 1'b1;
        real_result <= acc_m[W2-1:0];
      end else begin
        if (e_m[0]) acc_m <= (acc_m * b_m) % mod_m;
        b_m <= (b_m * b_m) % mod_m;
        e_m <= e_m >> 1;
      end
    end
  end

  assign eng_done   = (eng_mode == 0) ? real_done : (eng_mode == 2);
  assign eng_result = (eng_mode == 0) ? real_result : 16'hBEEF;

  typedef struct { int id; logic [W2-1:0] res; logic err; } exp_t;
  typedef struct {
    int id; logic [W2-1:0] base, modulo, exponent, res; logic err; int loads;
  } vec_t;

  exp_t          sb[$];
  int            total = 0, bad = 0, cyc = 0;
  int            load_count = 0, last_load_cyc = 0, rise_cyc = 0, pop_cyc = 0, grant_cyc = 0;
  logic [1:0]    prev_rsp = 2'b00;
  logic [W2-1:0] pend_res [2];
  logic          pend_err [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired before the DUT responded", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      check("protocol", {29'd0, (req_ready == 2'b00 || !busy), $onehot0(req_ready), $onehot0(rsp_valid)}, 32'd7);
      if (eng_load) begin
        load_count++;
        last_load_cyc = cyc;
      end
      if (rsp_valid != 2'b00 && prev_rsp == 2'b00) rise_cyc = cyc;
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        exp_t e;
        pop_cyc = cyc;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b with no job outstanding", rsp_valid);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", {30'd0, rsp_valid}, 32'd1 << e.id);
          check("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
          check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        end
      end
    end
    prev_rsp = rsp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [W2-1:0] b, m, x, r, input logic er);
    req_base[id*W2 +: W2]     = b;
    req_modulo[id*W2 +: W2]   = m;
    req_exponent[id*W2 +: W2] = x;
    pend_res[id]  = r;
    pend_err[id]  = er;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_grant(output int g);
    exp_t e;
    g = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != 2'b00) begin
        g = req_ready[1] ? 1 : 0;
        e.id = g; e.res = pend_res[g]; e.err = pend_err[g];
        sb.push_back(e);
        grant_cyc = cyc;
        break;
      end
    end
    if (g < 0) fail_bound("grant_timeout");
    else begin
      step();
      req_valid[g] = 1'b0;
    end
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d responses outstanding, required 0", sb.size());
    end
  endtask

  task automatic send_job(input int id, input logic [W2-1:0] b, m, x, r, input logic er);
    int g;
    step();
    set_req(id, b, m, x, r, er);
    wait_grant(g);
    check("grant_id", g, id);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   g, l0;
    logic seen;
    vec_t vecs[9];
    vecs[0] = '{0, 16'd4,     16'd497,   16'd13, 16'd445, 1'b0, 1};
    vecs[1] = '{1, 16'd3,     16'd7,     16'd5,  16'd5,   1'b0, 1};
    vecs[2] = '{0, 16'd7,     16'd13,    16'd0,  16'd1,   1'b0, 1};
    vecs[3] = '{1, 16'd2,     16'd1000,  16'd10, 16'd24,  1'b0, 1};
    vecs[4] = '{0, 16'd5,     16'd0,     16'd3,  16'd0,   1'b1, 0};
    vecs[5] = '{1, 16'd65535, 16'd65521, 16'd1,  16'd14,  1'b0, 1};
    vecs[6] = '{0, 16'd10,    16'd1,     16'd5,  16'd0,   1'b0, 1};
    vecs[7] = '{1, 16'd0,     16'd17,    16'd0,  16'd1,   1'b0, 1};
    vecs[8] = '{1, 16'd12345, 16'd0,     16'd0,  16'd0,   1'b1, 0};

    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    req_base = '0; req_modulo = '0; req_exponent = '0;
    set_req(0, 16'd3, 16'd7, 16'd5, 16'd5, 1'b0);
    set_req(1, 16'd7, 16'd13, 16'd0, 16'd1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", {30'd0, req_ready}, 32'd0);
    check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("reset_rsp_result", {16'd0, rsp_result}, 32'd0);
    check("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("reset_eng_load", {31'd0, eng_load}, 32'd0);
    check("reset_eng_ops", {eng_base, eng_modulo | eng_exponent}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    step();
    reset = 1'b0;

    // Both valid out of reset: requester 0 first, then 1, then 0 again.
    wait_grant(g); check("rr_first", g, 0);
    wait_grant(g); check("rr_second", g, 1);
    drain(100);
    step();
    set_req(0, 16'd3, 16'd100, 16'd4, 16'd81, 1'b0);
    set_req(1, 16'd2, 16'd1000, 16'd10, 16'd24, 1'b0);
    wait_grant(g); check("rr_third", g, 0);
    wait_grant(g); check("rr_fourth", g, 1);
    drain(100);

    for (int i = 0; i < 9; i++) begin
      l0 = load_count;
      send_job(vecs[i].id, vecs[i].base, vecs[i].modulo, vecs[i].exponent, vecs[i].res, vecs[i].err);
      drain(100);
      check("load_pulses", load_count - l0, vecs[i].loads);
      check("eng_modulo_hold", {16'd0, eng_modulo}, {16'd0, vecs[i].modulo});
    end

    l0 = load_count;
    send_job(0, 16'd5, 16'd0, 16'd3, 16'd0, 1'b1);
    drain(50);
    check("zero_mod_latency", rise_cyc - grant_cyc, 2);
    check("zero_mod_no_load", load_count - l0, 0);

    // TIMEOUT WAIT cycles follow the LOAD cycle, so RESP starts TIMEOUT+1 cycles after it.
    eng_mode = 1;
    send_job(1, 16'd5, 16'd11, 16'd3, 16'd0, 1'b1);
    drain(60);
    check("timeout_latency", rise_cyc - last_load_cyc, TIMEOUT + 1);

    eng_mode = 2;
    send_job(0, 16'd9, 16'd9, 16'd9, 16'hBEEF, 1'b0);
    drain(50);
    check("done_early_latency", rise_cyc - last_load_cyc, 3);

    // Response held off; non-winner ready and a competing request must both be ignored.
    step();
    eng_mode = 0;
    rsp_ready = 2'b01;
    send_job(1, 16'd3, 16'd7, 16'd5, 16'd5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (rsp_valid != 2'b00);
    end
    if (!seen) fail_bound("hold_rsp_wait");
    step();
    set_req(0, 16'd3, 16'd100, 16'd4, 16'd81, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", {30'd0, rsp_valid}, 32'd2);
      check("hold_rsp_result", {16'd0, rsp_result}, 32'd5);
      check("hold_rsp_error", {31'd0, rsp_error}, 32'd0);
      check("hold_req_ready", {30'd0, req_ready}, 32'd0);
    end
    step();
    rsp_ready = 2'b11;
    wait_grant(g);
    check("hold_grant", g, 0);
    check("idle_gap", grant_cyc - pop_cyc, 1);
    drain(100);

    // Reset in the middle of WAIT drops the job; a late done must not produce a response.
    step();
    set_req(0, 16'd4, 16'd497, 16'd13, 16'd445, 1'b0);
    wait_grant(g);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = eng_load;
    end
    if (!seen) fail_bound("mid_wait_load");
    step();
    step();
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    check("reset_mid_eng_base", {16'd0, eng_base}, 32'd0);
    eng_mode = 2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("late_done_rsp", {30'd0, rsp_valid}, 32'd0);
      check("late_done_busy", {31'd0, busy}, 32'd0);
    end
    step();
    eng_mode = 0;
    set_req(0, 16'd3, 16'd7, 16'd5, 16'd5, 1'b0);
    set_req(1, 16'd2, 16'd1000, 16'd10, 16'd24, 1'b0);
    wait_grant(g); check("ptr_after_reset", g, 0);
    wait_grant(g); check("second_after_reset", g, 1);
    drain(100);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modexp_arbiter.md
MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 8, SHALL set the half operand width; all operands and results are 2*WORDSIZE bits (W2).
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the maximum number of WAIT cycles before a job is aborted.
REQ-003 clk  in  1  SHALL be the clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be the reset, synchronous, active-high.
REQ-005 req_valid  in  2  SHALL carry the per-requester job request (bit i = requester i).
REQ-006 req_ready  out  2  SHALL carry the per-requester acceptance; a job transfers when req_valid[i] and req_ready[i] are both high.
REQ-007 req_base, req_modulo, req_exponent  in  2*W2 each  SHALL carry the operands; requester i uses slice [i*W2 +: W2].
REQ-008 rsp_valid  out  2  SHALL flag a result for requester i.
REQ-009 rsp_ready  in  2  SHALL carry the per-requester result acceptance.
REQ-010 rsp_result  out  W2  SHALL carry the result shared by both requesters, valid with rsp_valid.
REQ-011 rsp_error  out  1  SHALL flag an aborted job (zero modulo or timeout), valid with rsp_valid.
REQ-012 eng_base, eng_modulo, eng_exponent  out  W2 each  SHALL carry the operands to the shared modexp engine.
REQ-013 eng_load  out  1  SHALL be the engine start pulse, wired to the engine synchronous reset input.
REQ-014 eng_done  in  1  SHALL be the engine finish flag (level, holds high until the next load).
REQ-015 eng_result  in  W2  SHALL be the engine result, valid while eng_done is high.
REQ-016 busy  out  1  SHALL be high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT, RESP.
REQ-018 req_ready SHALL be nonzero only in IDLE, one-hot, and only for the requester selected by arbitration.
REQ-019 Arbitration SHALL be round-robin: a pointer names the preferred requester; with both valid, the preferred one wins; with one valid, it wins regardless of the pointer.
REQ-020 After each grant, the pointer SHALL move to the other requester.
REQ-021 The grant is combinational from req_valid and the pointer in IDLE; a requester SHALL NOT need to wait for ready before asserting valid.
REQ-022 On transfer, the operands SHALL be registered into the eng_* outputs, the winner index latched, and the FSM SHALL move to LOAD.
REQ-023 Exception to REQ-022: if the registered modulo is zero, the FSM SHALL go directly to RESP with rsp_error=1 and rsp_result=0, and eng_load SHALL never be asserted.
REQ-024 In LOAD, eng_load SHALL be high for exactly one cycle, followed by an unconditional move to WAIT with the timeout counter cleared.
REQ-025 In WAIT, eng_done SHALL be ignored during the first WAIT cycle.
REQ-026 From the second WAIT cycle on, eng_done=1 SHALL capture eng_result into rsp_result with rsp_error=0 and move to RESP.
REQ-027 In WAIT, the counter SHALL increment each cycle; on reaching TIMEOUT without eng_done, the FSM SHALL move to RESP with rsp_error=1 and rsp_result=0.
REQ-028 If eng_done and the timeout coincide, eng_done SHALL win.
REQ-029 In RESP, only rsp_valid[winner] SHALL be high; rsp_result and rsp_error SHALL hold stable until rsp_ready[winner] is high.
REQ-030 When rsp_ready[winner] is high in RESP, the FSM SHALL return to IDLE; rsp_ready of the non-winner SHALL be ignored.
REQ-031 A new request SHALL NOT be granted in the same cycle the response completes; minimum spacing between grants is one IDLE cycle.
REQ-032 eng_* operand outputs SHALL hold their last values outside LOAD and WAIT.
REQ-033 Exponent zero SHALL be a legal job, passed to the engine unchanged.

Reset
REQ-034 Reset SHALL force: FSM to IDLE, pointer to 0, req_ready=0 during reset, rsp_valid=0, rsp_result=0, rsp_error=0, eng_load=0, eng_* operands=0, counter=0, busy=0.
REQ-035 Reset asserted in any state, including mid-WAIT, SHALL drop the pending job with no response issued.
REQ-036 After a mid-WAIT reset, a late eng_done SHALL be ignored.

Verification
REQ-037 Job 4^13 mod 497 from requester 0 with a real engine, rsp_ready held high -> exactly one eng_load pulse, then rsp_valid=01, rsp_result=445, rsp_error=0.
REQ-038 Both requesters valid from reset: req1 with 7^0 mod 13, req0 with 3^5 mod 7 -> req0 served first with result 5, then req1 with result 1; the third grant goes to req0 if both are still valid.
REQ-039 Job with modulo=0 -> no eng_load; rsp_valid asserts 2 cycles after the transfer with rsp_error=1 and rsp_result=0.
REQ-040 Stub engine with eng_done stuck 0 and TIMEOUT=16 -> rsp_error=1 exactly 16 WAIT cycles after LOAD.
REQ-041 Stub engine with eng_done stuck 1 -> the first WAIT cycle is ignored; the result is captured on the second WAIT cycle.
REQ-042 Reset pulse mid-WAIT, then a new job -> no stale response; the new job completes correctly.
REQ-043 rsp_ready held low 10 cycles in RESP -> outputs stable, req_ready=00 throughout.
